// File: rtl/addr_map_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addr_map_prog : programmable pipelined SNES address decoder with a       |
// |                 shadow/active window bank and atomic commit              |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module addr_map_prog #(
  parameter int NUM_WIN = 8,
  parameter int AW      = 24,
  parameter int IW      = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [2:0]    cfg_sel,
  input  logic [AW-1:0] cfg_data,
  input  logic          cfg_rd,
  output logic [AW-1:0] cfg_rdata,
  input  logic          cfg_commit,
  input  logic [AW-1:0] SNES_ADDR,
  input  logic          addr_valid,
  output logic [AW-1:0] ROM_ADDR,
  output logic          ROM_HIT,
  output logic          IS_ROM,
  output logic          IS_SAVERAM,
  output logic          IS_WRITABLE,
  output logic [IW-1:0] hit_idx,
  output logic          out_valid
);

  localparam logic [2:0] C_SEL_MATCH = 3'd0;
  localparam logic [2:0] C_SEL_MASK  = 3'd1;
  localparam logic [2:0] C_SEL_BASE  = 3'd2;
  localparam logic [2:0] C_SEL_AMASK = 3'd3;
  localparam logic [2:0] C_SEL_ATTR  = 3'd4;

  logic [AW-1:0] r_sh_match [NUM_WIN];
  logic [AW-1:0] r_sh_mask  [NUM_WIN];
  logic [AW-1:0] r_sh_base  [NUM_WIN];
  logic [AW-1:0] r_sh_amask [NUM_WIN];
  logic [2:0]    r_sh_attr  [NUM_WIN];

  logic [AW-1:0] r_act_match [NUM_WIN];
  logic [AW-1:0] r_act_mask  [NUM_WIN];
  logic [AW-1:0] r_act_base  [NUM_WIN];
  logic [AW-1:0] r_act_amask [NUM_WIN];
  logic [2:0]    r_act_attr  [NUM_WIN];

  logic [NUM_WIN-1:0] w_win_hit;
  logic               w_hit;
  logic [IW-1:0]      w_idx;
  logic [AW-1:0]      w_base;
  logic [AW-1:0]      w_amask;
  logic               w_sr;
  logic               w_wr;
  logic [AW-1:0]      w_rd_val;

  logic               r_s1_valid;
  logic [AW-1:0]      r_s1_addr;
  logic               r_s1_hit;
  logic [IW-1:0]      r_s1_idx;
  logic [AW-1:0]      r_s1_base;
  logic [AW-1:0]      r_s1_amask;
  logic               r_s1_sr;
  logic               r_s1_wr;

  // Indices outside the window range never compare equal, so those writes drop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        r_sh_match[i] <= '0;
        r_sh_mask[i]  <= '0;
        r_sh_base[i]  <= '0;
        r_sh_amask[i] <= '0;
        r_sh_attr[i]  <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_idx == IW'(i)) begin
          case (cfg_sel)
            C_SEL_MATCH: r_sh_match[i] <= cfg_data;
            C_SEL_MASK:  r_sh_mask[i]  <= cfg_data;
            C_SEL_BASE:  r_sh_base[i]  <= cfg_data;
            C_SEL_AMASK: r_sh_amask[i] <= cfg_data;
            C_SEL_ATTR:  r_sh_attr[i]  <= cfg_data[2:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Commit samples the shadow before any same-edge write lands.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        r_act_match[i] <= '0;
        r_act_mask[i]  <= '0;
        r_act_base[i]  <= '0;
        r_act_amask[i] <= '0;
        r_act_attr[i]  <= '0;
      end
    end else if (cfg_commit) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        r_act_match[i] <= r_sh_match[i];
        r_act_mask[i]  <= r_sh_mask[i];
        r_act_base[i]  <= r_sh_base[i];
        r_act_amask[i] <= r_sh_amask[i];
        r_act_attr[i]  <= r_sh_attr[i];
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (cfg_idx == IW'(i)) begin
        case (cfg_sel)
          C_SEL_MATCH: w_rd_val = r_sh_match[i];
          C_SEL_MASK:  w_rd_val = r_sh_mask[i];
          C_SEL_BASE:  w_rd_val = r_sh_base[i];
          C_SEL_AMASK: w_rd_val = r_sh_amask[i];
          C_SEL_ATTR:  w_rd_val = {{(AW-3){1'b0}}, r_sh_attr[i]};
          default:     w_rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      cfg_rdata <= '0;
    else if (cfg_rd)
      cfg_rdata <= w_rd_val;
  end

  genvar g;
  for (g = 0; g < NUM_WIN; g++) begin : g_hit
    assign w_win_hit[g] = r_act_attr[g][0] &
                          ((SNES_ADDR & r_act_mask[g]) == (r_act_match[g] & r_act_mask[g]));
  end

  // Scan from the top so the lowest-index hitting window is assigned last.
  always_comb begin
    w_hit   = 1'b0;
    w_idx   = '0;
    w_base  = '0;
    w_amask = '0;
    w_sr    = 1'b0;
    w_wr    = 1'b0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (w_win_hit[i]) begin
        w_hit   = 1'b1;
        w_idx   = IW'(i);
        w_base  = r_act_base[i];
        w_amask = r_act_amask[i];
        w_sr    = r_act_attr[i][1];
        w_wr    = r_act_attr[i][2];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_base  <= '0;
      r_s1_amask <= '0;
      r_s1_sr    <= 1'b0;
      r_s1_wr    <= 1'b0;
    end else begin
      r_s1_valid <= addr_valid;
      if (addr_valid) begin
        r_s1_addr  <= SNES_ADDR;
        r_s1_hit   <= w_hit;
        r_s1_idx   <= w_idx;
        r_s1_base  <= w_base;
        r_s1_amask <= w_amask;
        r_s1_sr    <= w_sr;
        r_s1_wr    <= w_wr;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid   <= 1'b0;
      ROM_ADDR    <= '0;
      ROM_HIT     <= 1'b0;
      IS_ROM      <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      IS_WRITABLE <= 1'b0;
      hit_idx     <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        ROM_ADDR    <= r_s1_hit ? (r_s1_base + (r_s1_addr & r_s1_amask)) : '0;
        ROM_HIT     <= r_s1_hit;
        IS_ROM      <= r_s1_hit & ~r_s1_sr;
        IS_SAVERAM  <= r_s1_hit & r_s1_sr;
        IS_WRITABLE <= r_s1_hit & r_s1_wr;
        hit_idx     <= r_s1_hit ? r_s1_idx : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_map_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_addr_map_prog : directed, table-driven bench for addr_map_prog        |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_addr_map_prog;
  localparam int NUM_WIN = 8;
  localparam int AW      = 24;
  localparam int IW      = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [2:0]    cfg_sel;
  logic [AW-1:0] cfg_data;
  logic          cfg_rd;
  logic [AW-1:0] cfg_rdata;
  logic          cfg_commit;
  logic [AW-1:0] SNES_ADDR;
  logic          addr_valid;
  logic [AW-1:0] ROM_ADDR;
  logic          ROM_HIT;
  logic          IS_ROM;
  logic          IS_SAVERAM;
  logic          IS_WRITABLE;
  logic [IW-1:0] hit_idx;
  logic          out_valid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          hit;
    logic [IW-1:0] idx;
    logic [AW-1:0] rom_addr;
    logic          is_rom;
    logic          is_sr;
    logic          is_wr;
  } vec_t;

  vec_t vecs [8];

  addr_map_prog #(.NUM_WIN(NUM_WIN), .AW(AW), .IW(IW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_rd(cfg_rd), .cfg_rdata(cfg_rdata), .cfg_commit(cfg_commit),
    .SNES_ADDR(SNES_ADDR), .addr_valid(addr_valid),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_ROM(IS_ROM),
    .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE),
    .hit_idx(hit_idx), .out_valid(out_valid)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input int idx, input int sel, input logic [AW-1:0] data);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_sel = 3'(sel); cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int idx, input int sel, input logic [AW-1:0] exp);
    cfg_rd = 1'b1; cfg_idx = IW'(idx); cfg_sel = 3'(sel);
    tick();
    cfg_rd = 1'b0;
    chk(nm, 32'(cfg_rdata), 32'(exp));
  endtask

  task automatic commit_bank();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic chk_vec(input string nm, input vec_t v);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " ROM_HIT"}, 32'(ROM_HIT), 32'(v.hit));
    chk({nm, " ROM_ADDR"}, 32'(ROM_ADDR), 32'(v.rom_addr));
    chk({nm, " hit_idx"}, 32'(hit_idx), 32'(v.idx));
    chk({nm, " IS_ROM"}, 32'(IS_ROM), 32'(v.is_rom));
    chk({nm, " IS_SAVERAM"}, 32'(IS_SAVERAM), 32'(v.is_sr));
    chk({nm, " IS_WRITABLE"}, 32'(IS_WRITABLE), 32'(v.is_wr));
  endtask

  task automatic lookup(input string nm, input vec_t v);
    addr_valid = 1'b1; SNES_ADDR = v.addr;
    tick();
    addr_valid = 1'b0;
    chk({nm, " latency"}, 32'(out_valid), 32'd0);
    tick();
    chk_vec(nm, v);
  endtask

  initial begin
    vec_t v;
    RST_N = 1'b0; cfg_we = 0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
    cfg_rd = 0; cfg_commit = 0; SNES_ADDR = '0; addr_valid = 0;

    vecs[0] = '{24'h01FFFF, 1'b1, 4'd0, 24'h017FFF, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{24'h006123, 1'b1, 4'd2, 24'hE00123, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{24'h7E0000, 1'b1, 4'd5, 24'h100000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{24'h700020, 1'b1, 4'd1, 24'h000010, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{24'h12ABCD, 1'b1, 4'd0, 24'h122BCD, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{24'hC000AB, 1'b1, 4'd5, 24'h1000AB, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{24'h007FFF, 1'b1, 4'd2, 24'hE01FFF, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{24'h4080AA, 1'b1, 4'd5, 24'h1000AA, 1'b1, 1'b0, 1'b0};

    tick(); tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset ROM_ADDR", 32'(ROM_ADDR), 32'd0);
    chk("reset ROM_HIT", 32'(ROM_HIT), 32'd0);
    chk("reset cfg_rdata", 32'(cfg_rdata), 32'd0);
    RST_N = 1'b1;
    tick();

    v = '{24'h008000, 1'b0, 4'd0, 24'h000000, 1'b0, 1'b0, 1'b0};
    lookup("empty miss", v);

    wr(0, 0, 24'h008000); wr(0, 1, 24'h408000); wr(0, 2, 24'h000000);
    wr(0, 3, 24'h3F7FFF); wr(0, 4, 24'h000001);
    commit_bank();
    lookup("win0 only", vecs[0]);

    wr(1, 0, 24'h700000); wr(1, 1, 24'hFF0000); wr(1, 2, 24'hFFFFF0);
    wr(1, 3, 24'h0000FF); wr(1, 4, 24'h000001);
    wr(2, 0, 24'h006000); wr(2, 1, 24'h40E000); wr(2, 2, 24'hE00000);
    wr(2, 3, 24'h001FFF); wr(2, 4, 24'h000007);
    wr(5, 0, 24'h000000); wr(5, 1, 24'h000000); wr(5, 2, 24'h100000);
    wr(5, 3, 24'h0000FF); wr(5, 4, 24'h000001);
    v = '{24'h006123, 1'b1, 4'd5, 24'h100023, 1'b1, 1'b0, 1'b0};
    v.hit = 1'b0; v.idx = 4'd0; v.rom_addr = 24'h0; v.is_rom = 1'b0;
    lookup("shadow not active", v);
    commit_bank();

    for (int i = 0; i < 8; i++)
      lookup($sformatf("table[%0d]", i), vecs[i]);

    tick();
    chk("hold out_valid", 32'(out_valid), 32'd0);
    chk("hold ROM_ADDR", 32'(ROM_ADDR), 32'h1000AA);

    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        addr_valid = 1'b1; SNES_ADDR = vecs[i].addr;
      end else begin
        addr_valid = 1'b0;
      end
      tick();
      if (i >= 1) chk_vec($sformatf("stream[%0d]", i - 1), vecs[i - 1]);
    end
    addr_valid = 1'b0;
    tick();
    chk("stream end out_valid", 32'(out_valid), 32'd0);

    // Commit race: same-cycle lookup sees the old BASE, the next one the new.
    wr(0, 2, 24'h200000);
    cfg_commit = 1'b1; addr_valid = 1'b1; SNES_ADDR = 24'h12ABCD;
    tick();
    cfg_commit = 1'b0;
    tick();
    addr_valid = 1'b0;
    chk("race old base", 32'(ROM_ADDR), 32'h122BCD);
    chk("race old valid", 32'(out_valid), 32'd1);
    tick();
    chk("race new base", 32'(ROM_ADDR), 32'h322BCD);
    chk("race new valid", 32'(out_valid), 32'd1);

    // Write and commit together: active bank takes the pre-write shadow.
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_sel = 3'd2; cfg_data = 24'h300000; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    v = vecs[4]; v.rom_addr = 24'h322BCD;
    lookup("we+commit", v);
    rd_chk("we+commit shadow", 0, 2, 24'h300000);

    wr(NUM_WIN, 0, 24'hFFFFFF);
    wr(0, 6, 24'hABCDEF);
    rd_chk("rd win0 MATCH", 0, 0, 24'h008000);
    rd_chk("rd win0 MASK", 0, 1, 24'h408000);
    rd_chk("rd win2 ATTR", 2, 4, 24'h000007);
    tick();
    chk("rdata held", 32'(cfg_rdata), 32'h000007);
    rd_chk("rd bad idx", NUM_WIN, 0, 24'h0);
    rd_chk("rd reserved sel", 0, 6, 24'h0);
    rd_chk("rd win1 AMASK", 1, 3, 24'h0000FF);

    for (int i = 0; i < 3; i++) begin
      addr_valid = 1'b1; SNES_ADDR = vecs[i].addr;
      tick();
    end
    RST_N = 1'b0; addr_valid = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst ROM_ADDR", 32'(ROM_ADDR), 32'd0);
    chk("midrst ROM_HIT", 32'(ROM_HIT), 32'd0);
    chk("midrst hit_idx", 32'(hit_idx), 32'd0);
    chk("midrst cfg_rdata", 32'(cfg_rdata), 32'd0);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post-rst idle[%0d]", i), 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/addr_map_prog.md
Name: addr_map_prog

Overview:
- Programmable, pipelined successor to the fixed SNES address decoder.
- Holds NUM_WIN MCU-loaded mapping windows. Each window has a match/mask pair, a base offset, an address mask and attributes.
- Translates each sampled SNES address into an SRAM0 address plus ROM/SaveRAM/writable flags.
- Windows are staged in a shadow bank and take effect atomically on commit, so mapper changes never tear an in-flight lookup.

Parameters:
- NUM_WIN, 8, number of mapping windows (1..16); lower index has higher priority.
- AW, 24, SNES and SRAM address width.
- IW, 4, cfg_idx width; must satisfy 2^IW >= NUM_WIN.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- cfg_we  in  1  shadow write strobe, one CLK
- cfg_idx  in  IW  window index
- cfg_sel  in  3  field: 0 MATCH, 1 MASK, 2 BASE, 3 AMASK, 4 ATTR (5-7 reserved)
- cfg_data  in  AW  write data; ATTR uses bits [2:0] = {writable, saveram, enable}
- cfg_rd  in  1  shadow readback strobe
- cfg_rdata  out  AW  readback data, valid one cycle after cfg_rd
- cfg_commit  in  1  copy shadow bank to active bank
- SNES_ADDR  in  AW  address to translate
- addr_valid  in  1  SNES_ADDR sample strobe
- ROM_ADDR  out  AW  translated SRAM0 address
- ROM_HIT  out  1  some window hit
- IS_ROM  out  1  hit window is non-saveram
- IS_SAVERAM  out  1  hit window is saveram
- IS_WRITABLE  out  1  hit window is writable
- hit_idx  out  IW  index of winning window
- out_valid  out  1  outputs correspond to a new lookup

Behaviour:
- Reset:
  - Shadow and active banks all zero; all windows disabled.
  - All outputs 0, including cfg_rdata and out_valid.
  - Reset mid-lookup discards the lookup; no out_valid follows.
- Window hit rule: ATTR.enable & ((SNES_ADDR & MASK) == (MATCH & MASK)). MASK = 0 with enable set matches every address.
- Priority: lowest-index hitting window wins.
- Pipeline, latency 2, one lookup accepted per cycle:
  - Stage 1 (edge after addr_valid): register the sampled address, the hit flag, the winner index, and the winner's BASE, AMASK and ATTR, all taken from the active bank.
  - Stage 2 (next edge): ROM_ADDR = (BASE + (addr & AMASK)) mod 2^AW, then update all outputs.
  - out_valid pulses for one cycle, exactly 2 cycles after each addr_valid.
- Back-to-back addr_valid gives back-to-back out_valid.
- Outputs hold their last value while no lookup completes.
- Miss: ROM_HIT, IS_ROM, IS_SAVERAM and IS_WRITABLE are 0; ROM_ADDR is 0; hit_idx is 0; out_valid still pulses.
- Hit:
  - ROM_HIT = 1.
  - IS_SAVERAM = ATTR.saveram; IS_ROM = ~ATTR.saveram.
  - IS_WRITABLE = ATTR.writable.
- Config writes:
  - cfg_we updates only the shadow field.
  - cfg_idx >= NUM_WIN or cfg_sel >= 5: write ignored, readback returns 0.
- Commit:
  - cfg_commit copies the whole shadow bank to the active bank at that edge.
  - addr_valid in the same cycle as cfg_commit uses the OLD active bank.
  - addr_valid one cycle later uses the new bank.
  - A lookup already in stage 2 is unaffected, because stage 1 captured its window data.
- cfg_we and cfg_commit in the same cycle: commit copies the pre-write shadow; the write lands in the shadow only.
- cfg_rd: cfg_rdata = the shadow field selected by cfg_idx/cfg_sel, registered one cycle later; held until the next cfg_rd.
- Address arithmetic: AW bits unsigned; carry out of BASE + offset is discarded (wrap-around).

Test Plan:
- Reset, then addr_valid with SNES_ADDR=0x008000 → out_valid 2 cycles later, ROM_HIT=0, ROM_ADDR=0x000000.
- Window0: MATCH=0x008000, MASK=0x408000, BASE=0, AMASK=0x3F7FFF, ATTR=1. Commit, then lookup 0x01FFFF → ROM_HIT=1, IS_ROM=1, ROM_ADDR=0x017FFF, hit_idx=0.
- Overlap and wrap:
  - Window2 saveram: MATCH=0x006000, MASK=0x40E000, BASE=0xE00000, AMASK=0x001FFF, ATTR=7.
  - Window5: catch-all, MASK=0, ATTR=1.
  - Lookup 0x006123 → hit_idx=2, IS_SAVERAM=1, IS_WRITABLE=1, ROM_ADDR=0xE00123.
  - Lookup 0x7E0000 → hit_idx=5.
  - BASE=0xFFFFF0 with offset 0x20 → ROM_ADDR=0x000010.
- Commit race:
  - Change window0 BASE in shadow.
  - Assert cfg_commit together with addr_valid → result uses old BASE.
  - addr_valid the next cycle → result uses new BASE.
- Streaming: 8 consecutive addr_valid cycles → 8 consecutive out_valid with correct per-address results. Assert RST_N low mid-stream → outputs 0 immediately, no further out_valid.
- Config edges: write cfg_idx=NUM_WIN and cfg_sel=6 → no state change. cfg_rd on a valid field returns the written value one cycle later; reserved field returns 0.
